// File: rtl/risc_mem_responder.sv
// Memory-side responder for the 16-bit RISC core: latches a request, waits a
// programmable number of cycles, commits the access and pulses Ack.
module risc_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              We,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              Ack,
    output logic              Busy,
    output logic              Err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              ack_nxt, busy_nxt, err_nxt;
    logic              accept, commit;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        busy_nxt  = Busy;
        err_nxt   = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    accept    = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Initiator withdrew the request: abandon without touching memory
                if (!Req) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                commit    = 1'b1;
                ack_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Ack   <= 1'b0;
            Busy  <= 1'b0;
            Err   <= 1'b0;
            RData <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Ack   <= ack_nxt;
            Busy  <= busy_nxt;
            Err   <= err_nxt;
            if (commit && !we_q) begin
                RData <= mem[addr_q];
            end
        end
    end

    // Request fields are captured once so later bus changes cannot disturb the access
    always_ff @(posedge Clock) begin
        if (accept) begin
            we_q    <= We;
            addr_q  <= Addr;
            wdata_q <= WData;
        end
    end

    // Storage deliberately has no reset so contents survive Reset
    always_ff @(posedge Clock) begin
        if (commit && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_risc_mem_responder.sv
// Randomized self-checking bench for risc_mem_responder using an array model
// and the rule "Ack is registered WAIT_CYCLES+1 edges after acceptance".
module tb_risc_mem_responder;

    localparam int WA = 2;
    localparam int WB = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [7:0]  addr_a = '0;
    logic [15:0] wdata_a = '0, rdata_a;
    logic        ack_a, busy_a, err_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [7:0]  addr_b = '0;
    logic [15:0] wdata_b = '0, rdata_b;
    logic        ack_b, busy_b, err_b;

    logic [15:0] ma [256];
    logic [15:0] mb [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    risc_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(WA)) dut (
        .Clock(clk), .Reset(rst), .Req(req_a), .We(we_a), .Addr(addr_a),
        .WData(wdata_a), .RData(rdata_a), .Ack(ack_a), .Busy(busy_a), .Err(err_a)
    );

    risc_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(WB)) dut0 (
        .Clock(clk), .Reset(rst), .Req(req_b), .We(we_b), .Addr(addr_b),
        .WData(wdata_b), .RData(rdata_b), .Ack(ack_b), .Busy(busy_b), .Err(err_b)
    );

    // Drives one transaction and reports edges from acceptance to Ack.
    task automatic run_a(input logic w, input logic [7:0] a, input logic [15:0] d,
                         input bit keep, output int lat, output logic [15:0] rd,
                         output int busy_cyc, output bit saw_err);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        lat = -1; rd = 'x; busy_cyc = 0; saw_err = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy_a) busy_cyc++;
            if (err_a) saw_err = 1'b1;
            if (ack_a) begin
                lat = i - 1;
                rd  = rdata_a;
                break;
            end
        end
        if (!keep) req_a = 1'b0;
    endtask

    task automatic run_b(input logic w, input logic [7:0] a, input logic [15:0] d,
                         input bit keep, output int lat, output logic [15:0] rd,
                         output int busy_cyc, output bit saw_err);
        req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        lat = -1; rd = 'x; busy_cyc = 0; saw_err = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy_b) busy_cyc++;
            if (err_b) saw_err = 1'b1;
            if (ack_b) begin
                lat = i - 1;
                rd  = rdata_b;
                break;
            end
        end
        if (!keep) req_b = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ack_a, busy_a, err_a, rdata_a} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %h expected 0", {ack_a, busy_a, err_a, rdata_a});
        end
        n_cmp++;
        if ({ack_b, busy_b, err_b, rdata_b} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %h expected 0", {ack_b, busy_b, err_b, rdata_b});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_memories;
        int lat, bc; bit e; logic [15:0] rd, d;
        for (int a = 0; a < 256; a++) begin
            d = 16'($urandom);
            run_a(1'b1, 8'(a), d, 1'b0, lat, rd, bc, e);
            ma[a] = d;
            d = (a == 255) ? 16'h1234 : 16'($urandom);
            run_b(1'b1, 8'(a), d, 1'b0, lat, rd, bc, e);
            mb[a] = d;
            @(negedge clk);
        end
    endtask

    task automatic test_write_read;
        int lat, bc; bit e; logic [15:0] rd;
        run_a(1'b1, 8'h10, 16'hBEEF, 1'b0, lat, rd, bc, e);
        ma[8'h10] = 16'hBEEF;
        n_cmp++;
        if (lat !== WA + 1) begin
            n_bad++; $display("FAIL wr_latency: got %0d expected %0d", lat, WA + 1);
        end
        n_cmp++;
        if (bc !== 3) begin
            n_bad++; $display("FAIL wr_busy_cycles: got %0d expected 3", bc);
        end
        @(negedge clk);
        n_cmp++;
        if ({ack_a, busy_a, err_a} !== 3'b000) begin
            n_bad++; $display("FAIL ack_one_cycle: got %b expected 000", {ack_a, busy_a, err_a});
        end
        run_a(1'b0, 8'h10, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== 16'hBEEF || lat !== WA + 1) begin
            n_bad++; $display("FAIL rd_beef: got %h lat %0d expected beef lat %0d", rd, lat, WA + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_wait;
        int lat, bc; bit e; logic [15:0] rd;
        run_b(1'b0, 8'hFF, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== 16'h1234 || lat !== 1) begin
            n_bad++; $display("FAIL zero_wait: got %h lat %0d expected 1234 lat 1", rd, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, lat3, bc; bit e1, e2, e3; logic [15:0] rd;
        run_a(1'b1, 8'h01, 16'hAAAA, 1'b1, lat1, rd, bc, e1);
        run_a(1'b0, 8'h01, 16'h0000, 1'b1, lat2, rd, bc, e2);
        n_cmp++;
        if (rd !== 16'hAAAA) begin
            n_bad++; $display("FAIL b2b_read: got %h expected aaaa", rd);
        end
        run_a(1'b1, 8'h02, 16'h5555, 1'b0, lat3, rd, bc, e3);
        ma[8'h01] = 16'hAAAA;
        ma[8'h02] = 16'h5555;
        n_cmp++;
        if (lat1 !== WA + 1 || lat2 !== WA + 1 || lat3 !== WA + 1 || (e1 | e2 | e3)) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d %0d %0d err %b expected %0d each", lat1, lat2, lat3,
                     e1 | e2 | e3, WA + 1);
        end
        @(negedge clk);
        run_a(1'b0, 8'h02, 16'h0000, 1'b0, lat1, rd, bc, e1);
        n_cmp++;
        if (rd !== 16'h5555) begin
            n_bad++; $display("FAIL b2b_write2: got %h expected 5555", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int lat, bc; bit e; logic [15:0] rd;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h20; wdata_a = 16'h1111;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err_a, ack_a, busy_a} !== 3'b100) begin
            n_bad++; $display("FAIL abort_err: got %b expected 100", {err_a, ack_a, busy_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({err_a, ack_a} !== 2'b00) begin
            n_bad++; $display("FAIL abort_pulse: got %b expected 00", {err_a, ack_a});
        end
        run_a(1'b0, 8'h20, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== ma[8'h20]) begin
            n_bad++; $display("FAIL abort_nowrite: got %h expected %h", rd, ma[8'h20]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc; bit e; logic [15:0] rd;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h30; wdata_a = 16'h2222;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ack_a, busy_a, err_a, rdata_a} !== 19'd0) begin
            n_bad++; $display("FAIL reset_mid: got %h expected 0", {ack_a, busy_a, err_a, rdata_a});
        end
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_a(1'b0, 8'h30, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== ma[8'h30] || lat !== WA + 1) begin
            n_bad++;
            $display("FAIL reset_mid_mem: got %h lat %0d expected %h lat %0d", rd, lat, ma[8'h30], WA + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_change;
        int lat, bc; bit e; logic [15:0] rd, d;
        bit got_ack;
        d = 16'($urandom);
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; wdata_a = d;
        @(negedge clk);
        we_a = 1'b0; addr_a = 8'h41; wdata_a = ~d;
        got_ack = 1'b0;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk);
            got_ack = ack_a;
        end
        req_a = 1'b0;
        n_cmp++;
        if (!got_ack) begin
            n_bad++; $display("FAIL addr_change_ack: got no ack expected ack");
        end
        ma[8'h40] = d;
        @(negedge clk);
        run_a(1'b0, 8'h40, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== d) begin
            n_bad++; $display("FAIL addr_change_orig: got %h expected %h", rd, d);
        end
        @(negedge clk);
        run_a(1'b0, 8'h41, 16'h0000, 1'b0, lat, rd, bc, e);
        n_cmp++;
        if (rd !== ma[8'h41]) begin
            n_bad++; $display("FAIL addr_change_other: got %h expected %h", rd, ma[8'h41]);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, bc; bit e, keep; logic [15:0] rd, d; logic w; logic [7:0] a;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom); a = 8'($urandom); d = 16'($urandom);
            keep = (i != 29) && 1'($urandom);
            run_a(w, a, d, keep, lat, rd, bc, e);
            n_cmp++;
            if (lat !== WA + 1 || e || (!w && rd !== ma[a])) begin
                n_bad++;
                $display("FAIL rand_a[%0d]: got lat %0d rd %h err %b expected lat %0d rd %h", i, lat, rd, e,
                         WA + 1, ma[a]);
            end
            if (w) ma[a] = d;
            if (!keep) begin
                @(negedge clk);
                n_cmp++;
                if (ack_a !== 1'b0) begin
                    n_bad++; $display("FAIL rand_a_ack_end[%0d]: got %b expected 0", i, ack_a);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom); a = 8'($urandom); d = 16'($urandom);
            keep = (i != 29) && 1'($urandom);
            run_b(w, a, d, keep, lat, rd, bc, e);
            n_cmp++;
            if (lat !== WB + 1 || e || (!w && rd !== mb[a])) begin
                n_bad++;
                $display("FAIL rand_b[%0d]: got lat %0d rd %h err %b expected lat %0d rd %h", i, lat, rd, e,
                         WB + 1, mb[a]);
            end
            if (w) mb[a] = d;
            if (!keep) @(negedge clk);
        end
    endtask

    task automatic test_persist;
        int lat, bc; bit e; logic [15:0] rd; logic [7:0] a;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            run_a(1'b0, a, 16'h0000, 1'b0, lat, rd, bc, e);
            n_cmp++;
            if (rd !== ma[a]) begin
                n_bad++; $display("FAIL persist[%0d]: got %h expected %h", i, rd, ma[a]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        fill_memories();
        test_write_read();
        test_zero_wait();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_addr_change();
        test_random();
        test_persist();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
